mem_lsu_port: RTL and testbench

Load/store front end that drives the word-wide, one-cycle-latency main memory port. It accepts byte/half/word load and store requests from the core over a valid/ready handshake. It translates byte addresses into word indices and performs sub-word stores by read-modify-write, because the memory has no byte enables. It returns load data aligned and sign/zero-extended over a valid/ready response channel.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_lane.sv | 44 ++++
 rtl/mem_lsu_port.sv | 133 +++++++++++++
 tb/tb_mem_lsu_port.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the load/store memory port: access sizes, FSM states, word width.
package mem_pkg;

    localparam int unsigned WordW = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } state_e;

endpackage

// File: rtl/mem_lane.sv
// Combinational lane logic: extract/extend a sub-word for loads and merge
// store data into a word for read-modify-write.
module mem_lane
    import mem_pkg::*;
(
    input  logic [WordW-1:0] i_word,
    input  logic [WordW-1:0] i_wdata,
    input  logic [1:0]       i_off,
    input  size_e            i_size,
    input  logic             i_unsigned,
    output logic [WordW-1:0] o_rdata,
    output logic [WordW-1:0] o_merged
);

    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select by shift; half lane uses only addr[1].
    always_comb begin
        w_bsh  = {i_off, 3'b000};
        w_hsh  = {i_off[1], 4'b0000};
        w_byte = 8'(i_word >> w_bsh);
        w_half = 16'(i_word >> w_hsh);
        case (i_size)
            SZ_B: begin
                o_rdata  = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                o_merged = (i_word & ~(32'h0000_00FF << w_bsh))
                         | ({24'h0, i_wdata[7:0]} << w_bsh);
            end
            SZ_H: begin
                o_rdata  = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_merged = (i_word & ~(32'h0000_FFFF << w_hsh))
                         | ({16'h0, i_wdata[15:0]} << w_hsh);
            end
            default: begin
                o_rdata  = i_word;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu_port.sv
// Load/store front end for a word-wide, one-cycle-latency memory without
// byte enables. Sub-word stores go through read-modify-write.
module mem_lsu_port
    import mem_pkg::*;
#(
    parameter int unsigned _D = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read_en,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data,
    output logic        mem_write_en,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data
);

    state_e      r_state;
    state_e      w_state_d;
    logic [29:0] r_idx;
    logic [1:0]  r_off;
    size_e       r_size;
    logic        r_uns;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_wdata;
    logic [31:0] r_wword;
    logic [31:0] r_rdata;

    size_e       w_size;
    logic        w_misalign;
    logic        w_err;
    logic        w_accept;
    logic [31:0] w_lane_rdata;
    logic [31:0] w_merged;

    assign w_size   = size_e'(req_size);
    assign w_accept = req_valid && (r_state == IDLE);

    // Request legality: size, alignment and word-index range.
    always_comb begin
        case (w_size)
            SZ_H:    w_misalign = req_addr[0];
            SZ_W:    w_misalign = |req_addr[1:0];
            SZ_X:    w_misalign = 1'b1;
            default: w_misalign = 1'b0;
        endcase
        w_err = w_misalign | ({2'b00, req_addr[31:2]} >= _D);
    end

    // Next-state: word stores skip the read, errors go straight to the response.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_err)                        w_state_d = RSP;
                    else if (req_we && w_size == SZ_W) w_state_d = WR;
                    else                              w_state_d = RD;
                end
            end
            RD:      w_state_d = CAP;
            CAP:     w_state_d = r_we ? WR : RSP;
            WR:      w_state_d = RSP;
            RSP:     if (rsp_ready) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    mem_lane u_lane (
        .i_word     (mem_read_data),
        .i_wdata    (r_wdata),
        .i_off      (r_off),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_rdata    (w_lane_rdata),
        .o_merged   (w_merged)
    );

    // State and request/response registers; CAP samples the memory word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_off   <= '0;
            r_size  <= SZ_B;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_wword <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_idx   <= req_addr[31:2];
                r_off   <= req_addr[1:0];
                r_size  <= w_size;
                r_uns   <= req_unsigned;
                r_we    <= req_we;
                r_err   <= w_err;
                r_wdata <= req_wdata;
                r_wword <= req_wdata;
                r_rdata <= '0;
            end else if (r_state == CAP) begin
                if (r_we) r_wword <= w_merged;
                else      r_rdata <= w_lane_rdata;
            end
        end
    end

    assign req_ready      = (r_state == IDLE);
    assign rsp_valid      = (r_state == RSP);
    assign rsp_rdata      = rsp_valid ? r_rdata : 32'h0;
    assign rsp_err        = rsp_valid & r_err;
    assign mem_read_en    = (r_state == RD);
    assign mem_read_addr  = mem_read_en ? {2'b00, r_idx} : 32'h0;
    assign mem_write_en   = (r_state == WR);
    assign mem_write_addr = mem_write_en ? {2'b00, r_idx} : 32'h0;
    assign mem_write_data = mem_write_en ? r_wword : 32'h0;

endmodule

// File: tb/tb_mem_lsu_port.sv
// Self-checking bench for mem_lsu_port: directed scenarios plus randomized
// traffic checked against a byte-level reference memory.
module tb_mem_lsu_port;

    localparam int unsigned D = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read_en;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_lsu_port #(._D(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_read_en    (mem_read_en),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
    );

    // Memory environment: one-cycle read latency, zero-filled on the first edge.
    logic [31:0] mem [0:D-1];
    logic [31:0] mem_rd_q = 32'h0;
    bit          mem_init_done;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(D); i++) mem[i] <= 32'h0;
            mem_init_done <= 1'b1;
        end else if (mem_write_en) begin
            mem[mem_write_addr[9:0]] <= mem_write_data;
        end
        if (mem_read_en) mem_rd_q <= mem[mem_read_addr[9:0]];
    end
    assign mem_read_data = mem_rd_q;

    // Reference memory, updated only by completed legal stores.
    logic [31:0] ref_mem [0:D-1];

    // Expected outcome of one request from the architectural rules.
    function automatic void ref_op(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   output logic [31:0] rd, output logic err, output int lat);
        int unsigned nbytes;
        int unsigned idx;
        int unsigned sh;
        logic [31:0] mask;
        logic [31:0] word;
        logic [31:0] v;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        idx    = addr / 4;
        err    = (sz == 2'b11) || ((addr % nbytes) != 0) || (idx >= D);
        rd     = 32'h0;
        if (err) begin
            lat = 1;
            return;
        end
        mask = (nbytes == 1) ? 32'h0000_00FF : (nbytes == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        sh   = 8 * (addr % 4);
        word = ref_mem[idx];
        if (!we) begin
            v = (word >> sh) & mask;
            if (!uns && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 1) == 1) v = v | ~mask;
            rd  = v;
            lat = 3;
        end else begin
            ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
            lat = (nbytes == 4) ? 2 : 4;
        end
    endfunction

    // Observations of the last transaction driven by do_req.
    int          g_rd_cyc, g_wr_cyc, g_rsp_cyc, g_strobes;
    logic [31:0] g_rd_addr, g_wr_addr, g_wr_data, g_rdata;
    logic        g_err;
    logic        g_accepted;

    // Drive one request from a negedge with rsp_ready high; record per-cycle activity.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        g_rd_cyc = -1; g_wr_cyc = -1; g_rsp_cyc = -1; g_strobes = 0;
        g_rd_addr = 0; g_wr_addr = 0; g_wr_data = 0; g_rdata = 0; g_err = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
        g_accepted = req_ready;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_read_en) begin
                g_strobes++; g_rd_cyc = c; g_rd_addr = mem_read_addr;
            end
            if (mem_write_en) begin
                g_strobes++; g_wr_cyc = c; g_wr_addr = mem_write_addr; g_wr_data = mem_write_data;
            end
            if (rsp_valid) begin
                g_rsp_cyc = c; g_rdata = rsp_rdata; g_err = rsp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0; rsp_ready = 1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        n_tests++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
            n_fail++; $display("FAIL reset_rsp got=%b/%b/%h exp=0/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        n_tests++;
        if ({mem_read_en, mem_write_en, mem_read_addr, mem_write_addr, mem_write_data} !== 98'h0) begin
            n_fail++;
            $display("FAIL reset_mem got=%b %b %h %h %h exp=all zero", mem_read_en, mem_write_en,
                     mem_read_addr, mem_write_addr, mem_write_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        logic [31:0] rd; logic er; int lat;
        ref_op(1, 2'b10, 0, 32'h14, 32'h8899AABB, rd, er, lat);
        do_req(1, 2'b10, 0, 32'h14, 32'h8899AABB);
        ref_op(0, 2'b00, 0, 32'h15, 0, rd, er, lat);
        do_req(0, 2'b00, 0, 32'h15, 0);
        n_tests++;
        if (g_rd_cyc !== 1 || g_rd_addr !== 32'd5) begin
            n_fail++; $display("FAIL load_byte_read got cyc=%0d addr=%h exp cyc=1 addr=5", g_rd_cyc, g_rd_addr);
        end
        n_tests++;
        if (g_rsp_cyc !== 3 || g_rdata !== 32'hFFFFFFAA || g_err !== 1'b0) begin
            n_fail++;
            $display("FAIL load_byte_signed got cyc=%0d data=%h err=%b exp cyc=3 data=ffffffaa err=0",
                     g_rsp_cyc, g_rdata, g_err);
        end
        ref_op(0, 2'b00, 1, 32'h15, 0, rd, er, lat);
        do_req(0, 2'b00, 1, 32'h15, 0);
        n_tests++;
        if (g_rsp_cyc !== 3 || g_rdata !== 32'h000000AA) begin
            n_fail++; $display("FAIL load_byte_unsigned got cyc=%0d data=%h exp cyc=3 data=000000aa",
                               g_rsp_cyc, g_rdata);
        end
    endtask

    task automatic test_half_store();
        logic [31:0] rd; logic er; int lat;
        ref_op(1, 2'b10, 0, 32'h08, 32'h11223344, rd, er, lat);
        do_req(1, 2'b10, 0, 32'h08, 32'h11223344);
        ref_op(1, 2'b01, 0, 32'h0A, 32'h0000BEEF, rd, er, lat);
        do_req(1, 2'b01, 0, 32'h0A, 32'h0000BEEF);
        n_tests++;
        if (g_rd_cyc !== 1 || g_rd_addr !== 32'd2) begin
            n_fail++; $display("FAIL half_store_read got cyc=%0d addr=%h exp cyc=1 addr=2", g_rd_cyc, g_rd_addr);
        end
        n_tests++;
        if (g_wr_cyc !== 3 || g_wr_addr !== 32'd2 || g_wr_data !== 32'hBEEF3344) begin
            n_fail++; $display("FAIL half_store_write got cyc=%0d addr=%h data=%h exp cyc=3 addr=2 data=beef3344",
                               g_wr_cyc, g_wr_addr, g_wr_data);
        end
        n_tests++;
        if (g_rsp_cyc !== 4 || g_err !== 1'b0 || g_rdata !== 32'h0) begin
            n_fail++; $display("FAIL half_store_rsp got cyc=%0d err=%b data=%h exp cyc=4 err=0 data=0",
                               g_rsp_cyc, g_err, g_rdata);
        end
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd; logic er; int lat;
        ref_op(1, 2'b10, 0, 32'h40, 32'hDEADBEEF, rd, er, lat);
        do_req(1, 2'b10, 0, 32'h40, 32'hDEADBEEF);
        n_tests++;
        if (g_wr_cyc !== 1 || g_wr_addr !== 32'd16 || g_wr_data !== 32'hDEADBEEF || g_strobes !== 1) begin
            n_fail++; $display("FAIL word_store_write got cyc=%0d addr=%h data=%h strobes=%0d exp 1/10/deadbeef/1",
                               g_wr_cyc, g_wr_addr, g_wr_data, g_strobes);
        end
        n_tests++;
        if (g_rsp_cyc !== 2 || g_err !== 1'b0) begin
            n_fail++; $display("FAIL word_store_rsp got cyc=%0d err=%b exp cyc=2 err=0", g_rsp_cyc, g_err);
        end
        ref_op(0, 2'b10, 0, 32'h40, 0, rd, er, lat);
        do_req(0, 2'b10, 0, 32'h40, 0);
        n_tests++;
        if (g_rsp_cyc !== 3 || g_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL word_load got cyc=%0d data=%h exp cyc=3 data=deadbeef", g_rsp_cyc, g_rdata);
        end
    endtask

    task automatic test_errors();
        logic        t_we [4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  t_sz [4]   = '{2'b01, 2'b10, 2'b10, 2'b11};
        logic [31:0] t_addr [4] = '{32'h3, 32'h1002, 32'h1000, 32'h20};
        for (int i = 0; i < 4; i++) begin
            do_req(t_we[i], t_sz[i], 0, t_addr[i], 32'hFFFF_FFFF);
            n_tests++;
            if (g_rsp_cyc !== 1 || g_err !== 1'b1 || g_rdata !== 32'h0) begin
                n_fail++; $display("FAIL error_rsp[%0d] got cyc=%0d err=%b data=%h exp cyc=1 err=1 data=0",
                                   i, g_rsp_cyc, g_err, g_rdata);
            end
            n_tests++;
            if (g_strobes !== 0) begin
                n_fail++; $display("FAIL error_no_mem[%0d] got strobes=%0d exp 0", i, g_strobes);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; bit seen;
        ref_op(0, 2'b01, 0, 32'h16, 0, rd, er, lat);
        req_valid = 1; req_we = 0; req_size = 2'b01; req_unsigned = 0;
        req_addr = 32'h16; req_wdata = 0; rsp_ready = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (rsp_valid) seen = 1;
            else @(negedge clk);
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL backpressure_rsp_timeout got rsp_valid=0 exp 1");
        end
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || req_ready !== 1'b0 ||
                mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
                n_fail++; $display("FAIL backpressure_hold[%0d] got v=%b data=%h rdy=%b rd=%b wr=%b exp 1/%h/0/0/0",
                                   c, rsp_valid, rsp_rdata, req_ready, mem_read_en, mem_write_en, rd);
            end
            @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_release got rdy=%b v=%b exp rdy=1 v=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; bit wr_seen;
        ref_op(1, 2'b10, 0, 32'h1C, 32'hCAFEF00D, rd, er, lat);
        do_req(1, 2'b10, 0, 32'h1C, 32'hCAFEF00D);
        req_valid = 1; req_we = 1; req_size = 2'b00; req_unsigned = 0;
        req_addr = 32'h1D; req_wdata = 32'h55; rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        n_tests++;
        if (mem_read_en !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_rd got rd=%b exp 1", mem_read_en);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (mem_write_en !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_read_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_immediate got wr=%b rdy=%b v=%b rd=%b exp 0/1/0/0",
                               mem_write_en, req_ready, rsp_valid, mem_read_en);
        end
        wr_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (mem_write_en) wr_seen = 1;
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_ready got rdy=%b exp 1", req_ready);
        end
        repeat (3) begin
            @(negedge clk);
            if (mem_write_en) wr_seen = 1;
        end
        n_tests++;
        if (wr_seen) begin
            n_fail++; $display("FAIL reset_mid_no_write got write pulse exp none");
        end
        n_tests++;
        if (mem[7] !== 32'hCAFEF00D || mem[7] !== ref_mem[7]) begin
            n_fail++; $display("FAIL reset_mid_mem got %h exp cafef00d", mem[7]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat;
        logic        we, uns;
        logic [1:0]  sz;
        int unsigned idx;
        logic [31:0] addr, wd;
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom);
            uns = 1'($urandom);
            sz  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            idx = ($urandom_range(0, 9) == 0) ? D + $urandom_range(0, 3) : $urandom_range(0, 15);
            addr = (idx << 2) | $urandom_range(0, 3);
            wd   = $urandom;
            ref_op(we, sz, uns, addr, wd, rd, er, lat);
            do_req(we, sz, uns, addr, wd);
            n_tests++;
            if (g_accepted !== 1'b1 || g_rsp_cyc !== lat || g_err !== er || g_rdata !== rd) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b sz=%b a=%h got acc=%b cyc=%0d err=%b data=%h exp acc=1 cyc=%0d err=%b data=%h",
                         i, we, sz, addr, g_accepted, g_rsp_cyc, g_err, g_rdata, lat, er, rd);
            end
        end
        for (int w = 0; w < 16; w++) begin
            n_tests++;
            if (mem[w] !== ref_mem[w]) begin
                n_fail++; $display("FAIL random_mem[%0d] got %h exp %h", w, mem[w], ref_mem[w]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(D); i++) ref_mem[i] = 32'h0;
        test_reset();
        test_load_byte();
        test_half_store();
        test_word_store_load();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
